// File: rtl/rtc_bus_ctrl.sv
// ============================================================================
// rtc_bus_ctrl : RTC multiplexed address/data bus sequencer      rev 1.0
// ============================================================================
`default_nettype none

module rtc_bus_ctrl #(
  parameter int unsigned T_PH  = 10,
  parameter int unsigned T_GAP = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] Address,
  input  logic [7:0] Data,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD,
  output logic [7:0] Data_R,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] PH_LAST  = 8'(T_PH - 1);
  localparam logic [7:0] GAP_LAST = 8'(T_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR_SET  = 4'd1,
    S_ADDR_STB  = 4'd2,
    S_ADDR_HOLD = 4'd3,
    S_GAP       = 4'd4,
    S_DATA_SET  = 4'd5,
    S_DATA_STB  = 4'd6,
    S_DATA_HOLD = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       rw_q, rw_d;
  logic [7:0] data_r_q, data_r_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       bus_oe_q, bus_oe_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       ad_q, ad_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       phase_end;

  always_comb begin : next_state
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = rw_q;
    data_r_d  = data_r_q;
    phase_end = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: phase_end = 1'b1;
      S_GAP:          phase_end = (cnt_q == GAP_LAST);
      default:        phase_end = (cnt_q == PH_LAST);
    endcase

    if (state_q == S_IDLE) begin
      if (start) begin
        addr_d  = Address;
        data_d  = Data;
        rw_d    = rw;
        cnt_d   = 8'd0;
        state_d = S_ADDR_SET;
      end
    end else if (phase_end) begin
      cnt_d = 8'd0;
      case (state_q)
        S_ADDR_SET:  state_d = S_ADDR_STB;
        S_ADDR_STB:  state_d = S_ADDR_HOLD;
        S_ADDR_HOLD: state_d = S_GAP;
        S_GAP:       state_d = S_DATA_SET;
        S_DATA_SET:  state_d = S_DATA_STB;
        S_DATA_STB:  state_d = S_DATA_HOLD;
        S_DATA_HOLD: state_d = S_DONE;
        default:     state_d = S_IDLE;
      endcase
      // RD_n is low for the whole of DATA_STB, so bus_in is settled on its last cycle
      if (state_q == S_DATA_STB && !rw_q) begin
        data_r_d = bus_in;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Pins are decoded from the next state so every output leaves a flop
  always_comb begin : out_decode
    cs_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    ad_d      = 1'b1;
    bus_oe_d  = 1'b0;
    bus_out_d = bus_out_q;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);

    case (state_d)
      S_ADDR_SET, S_ADDR_STB, S_ADDR_HOLD: begin
        cs_n_d    = 1'b0;
        ad_d      = 1'b0;
        bus_oe_d  = 1'b1;
        bus_out_d = addr_d;
        wr_n_d    = (state_d != S_ADDR_STB);
      end
      S_DATA_SET, S_DATA_STB, S_DATA_HOLD: begin
        cs_n_d = 1'b0;
        if (rw_d) begin
          bus_oe_d  = 1'b1;
          bus_out_d = data_d;
          wr_n_d    = (state_d != S_DATA_STB);
        end else begin
          rd_n_d = (state_d != S_DATA_STB);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      rw_q      <= 1'b0;
      data_r_q  <= 8'd0;
      bus_out_q <= 8'd0;
      bus_oe_q  <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      data_r_q  <= data_r_d;
      bus_out_q <= bus_out_d;
      bus_oe_q  <= bus_oe_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_q      <= ad_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus_out = bus_out_q;
  assign bus_oe  = bus_oe_q;
  assign CS_n    = cs_n_q;
  assign RD_n    = rd_n_q;
  assign WR_n    = wr_n_q;
  assign AD      = ad_q;
  assign Data_R  = data_r_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_ctrl.sv
// ============================================================================
// tb_rtc_bus_ctrl : randomized self-checking bench for rtc_bus_ctrl   rev 1.0
// ============================================================================
`default_nettype none

module tb_rtc_bus_ctrl;

  localparam int T_PH   = 10;
  localparam int T_GAP  = 5;
  localparam int TXN    = 6 * T_PH + T_GAP + 1;   // cycles from accept to IDLE
  localparam int LAST_K = TXN - 1;                // transaction cycle index of DONE

  logic       clk = 1'b0;
  logic       reset, start, rw;
  logic [7:0] Address, Data, bus_in, bus_out, Data_R;
  logic       bus_oe, CS_n, RD_n, WR_n, AD, busy, done;

  logic [7:0] rd_val, junk;
  // RTC pin model: presents the read byte only while RD_n is low
  assign bus_in = (RD_n === 1'b0) ? rd_val : junk;

  always #5 clk = ~clk;

  rtc_bus_ctrl #(.T_PH(T_PH), .T_GAP(T_GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw),
    .Address(Address), .Data(Data), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .CS_n(CS_n), .RD_n(RD_n),
    .WR_n(WR_n), .AD(AD), .Data_R(Data_R), .busy(busy), .done(done)
  );

  // reference model: transaction active flag and cycle index within it
  bit         m_act;
  int         m_k;
  bit         m_rw;
  logic [7:0] m_addr, m_data, m_dr;
  bit         fresh;
  int         cyc, acc_cyc, last_done_cyc, gap_run;
  int         n_checks, n_fail, n_done_dut, n_done_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare();
    logic [6:0] exp_pins;   // {CS_n,RD_n,WR_n,AD,bus_oe,busy,done}
    logic [7:0] exp_bo;
    bit         stb;
    int         j;
    exp_pins = 7'b1111_000;
    exp_bo   = 8'h00;
    if (m_act) begin
      if (m_k < 3 * T_PH) begin
        stb      = (m_k >= T_PH) && (m_k < 2 * T_PH);
        exp_pins = {1'b0, 1'b1, !stb, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_bo   = m_addr;
      end else if (m_k < 3 * T_PH + T_GAP) begin
        exp_pins = 7'b1111_010;
      end else if (m_k < 6 * T_PH + T_GAP) begin
        j   = m_k - (3 * T_PH + T_GAP);
        stb = (j >= T_PH) && (j < 2 * T_PH);
        if (m_rw) begin
          exp_pins = {1'b0, 1'b1, !stb, 1'b1, 1'b1, 1'b1, 1'b0};
          exp_bo   = m_data;
        end else begin
          exp_pins = {1'b0, !stb, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        end
      end else begin
        exp_pins = 7'b1111_011;
        n_done_exp++;
      end
    end
    check_eq("pins", 32'({CS_n, RD_n, WR_n, AD, bus_oe, busy, done}), 32'(exp_pins));
    if (exp_pins[2]) check_eq("bus_out", 32'(bus_out), 32'(exp_bo));
    else if (fresh)  check_eq("bus_out_rst", 32'(bus_out), 32'h0);
    check_eq("data_r", 32'(Data_R), 32'(m_dr));

    check_eq("rd_wr_both_low", 32'(RD_n === 1'b0 && WR_n === 1'b0), 32'h0);
    check_eq("oe_during_rd", 32'(bus_oe === 1'b1 && RD_n === 1'b0), 32'h0);
    if (busy !== 1'b1) gap_run = 0;
    else if (CS_n === 1'b1) gap_run++;
    else begin
      if (gap_run != 0) check_eq("gap_len", 32'(gap_run), 32'(T_GAP));
      gap_run = 0;
    end
    if (done === 1'b1) begin
      n_done_dut++;
      last_done_cyc = cyc;
      check_eq("done_cycle", 32'(cyc - acc_cyc + 1), 32'(TXN));
    end
  endtask

  // one clock: advance the model with the inputs in force, then check at negedge
  task automatic tick();
    junk = rd_val ^ 8'($urandom_range(1, 255));
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_act = 1'b0;
      m_dr  = 8'h00;
      fresh = 1'b1;
    end else if (m_act) begin
      if (!m_rw && m_k == 5 * T_PH + T_GAP - 1) m_dr = rd_val;
      if (m_k == LAST_K) m_act = 1'b0;
      else m_k++;
    end else if (start) begin
      m_act   = 1'b1;
      m_k     = 0;
      m_rw    = rw;
      m_addr  = Address;
      m_data  = Data;
      fresh   = 1'b0;
      acc_cyc = cyc;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic run_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] r, input bit noisy);
    rd_val  = r;
    rw      = w;
    Address = a;
    Data    = d;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4 * TXN && m_act; i++) begin
      if (noisy) begin
        Address = 8'($urandom);
        Data    = 8'($urandom);
        rw      = 1'($urandom);
        start   = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int first_acc;
    reset = 1'b1; start = 1'b0; rw = 1'b0; Address = 8'h00; Data = 8'h00;
    rd_val = 8'h00; junk = 8'h5A;
    m_act = 1'b0; m_k = 0; m_rw = 1'b0; m_addr = 8'h00; m_data = 8'h00; m_dr = 8'h00;
    fresh = 1'b1; cyc = 0; acc_cyc = 0; last_done_cyc = 0; gap_run = 0;
    n_checks = 0; n_fail = 0; n_done_dut = 0; n_done_exp = 0;

    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_bus_out", 32'(bus_out), 32'h0);
    check_eq("rst_data_r", 32'(Data_R), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);

    run_txn(1'b1, 8'h02, 8'h45, 8'h00, 1'b0);
    run_txn(1'b0, 8'h04, 8'h99, 8'h23, 1'b0);
    check_eq("read_data_r", 32'(Data_R), 32'h23);
    run_txn(1'b1, 8'h11, 8'h22, 8'h00, 1'b1);
    check_eq("write_keeps_data_r", 32'(Data_R), 32'h23);

    // abort a write in the middle of its data strobe
    rw = 1'b1; Address = 8'h33; Data = 8'h44; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < TXN && m_k < 4 * T_PH + T_GAP + 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_wr_n", 32'(WR_n), 32'h1);
    check_eq("abort_busy", 32'(busy), 32'h0);
    run_txn(1'b1, 8'h55, 8'h66, 8'h00, 1'b0);

    // back-to-back writes, second start on the cycle after done
    run_txn(1'b1, 8'h21, 8'h30, 8'h00, 1'b0);
    first_acc = acc_cyc;
    run_txn(1'b1, 8'h22, 8'h59, 8'h00, 1'b0);
    check_eq("b2b_total", 32'(last_done_cyc - first_acc + 1), 32'(2 * TXN + 1));

    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 599) == 0);
      start   = ($urandom_range(0, 5) == 0);
      rw      = 1'($urandom);
      Address = 8'($urandom);
      Data    = 8'($urandom);
      if (!m_act) rd_val = 8'($urandom);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2 * TXN && m_act; i++) tick();
    check_eq("done_count", 32'(n_done_dut), 32'(n_done_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rtc_bus_ctrl.md
RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 Parameter T_PH, default 10, SHALL set the clock cycles per bus phase (legal range 1..255).
REQ-002 Parameter T_GAP, default 5, SHALL set the clock cycles CS_n stays high between the address and data cycles (legal range 1..255).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle request to run a bus transaction.
REQ-007 rw  in  1  transaction type: 1 = write, 0 = read.
REQ-008 Address  in  8  RTC register address, from the write-path mux.
REQ-009 Data  in  8  write data, from the write-path mux.
REQ-010 bus_in  in  8  value sampled from the RTC address/data pins.
REQ-011 bus_out  out  8  value driven onto the RTC address/data pins.
REQ-012 bus_oe  out  1  1 = pad tristate enabled, driving bus_out.
REQ-013 CS_n, RD_n, WR_n, AD  out  1 each  RTC chip select, read strobe, write strobe and address/data select (0 = address phase).
REQ-014 Data_R  out  8  last read byte.
REQ-015 busy  out  1  transaction in progress.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 start SHALL be accepted only in IDLE; acceptance SHALL latch Address, Data and rw, which stay stable for the whole transaction.
REQ-018 start while busy=1 SHALL be ignored, with no queuing.
REQ-019 The states SHALL run in this order: IDLE -> ADDR_SET -> ADDR_STB -> ADDR_HOLD -> GAP -> DATA_SET -> DATA_STB -> DATA_HOLD -> DONE -> IDLE.
REQ-020 Each of ADDR_SET, ADDR_STB, ADDR_HOLD, DATA_SET, DATA_STB and DATA_HOLD SHALL last exactly T_PH cycles, GAP exactly T_GAP cycles and DONE exactly 1 cycle, timed by an 8-bit phase counter.
REQ-021 In IDLE and DONE, the outputs SHALL be CS_n=1, RD_n=1, WR_n=1, AD=1, bus_oe=0.
REQ-022 In ADDR_SET, ADDR_STB and ADDR_HOLD, the outputs SHALL be CS_n=0, AD=0, bus_oe=1, bus_out=latched Address, with WR_n=0 only in ADDR_STB.
REQ-023 In GAP, the outputs SHALL be CS_n=1, AD=1, bus_oe=0, all strobes high.
REQ-024 In DATA_SET, DATA_STB and DATA_HOLD, the outputs SHALL be CS_n=0 and AD=1.
REQ-025 In the data states of a write, the outputs SHALL be bus_oe=1 and bus_out=latched Data, with WR_n=0 only in DATA_STB.
REQ-026 In the data states of a read, the outputs SHALL be bus_oe=0, with RD_n=0 only in DATA_STB.
REQ-027 A read SHALL load bus_in into Data_R on the last cycle of DATA_STB.
REQ-028 Data_R SHALL be unchanged by writes and SHALL hold its value until the next read.
REQ-029 RD_n and WR_n SHALL never both be 0.
REQ-030 bus_oe SHALL never be 1 while RD_n=0.
REQ-031 busy SHALL be 1 from the cycle after start is accepted through DONE inclusive.
REQ-032 done SHALL be 1 only in DONE, exactly 6*T_PH+T_GAP+1 cycles after the start-accept edge.
REQ-033 A new start SHALL be accepted on the first IDLE cycle after DONE, giving back-to-back transactions with a 1-cycle IDLE gap.
REQ-034 All outputs SHALL be registered, with no combinational path from inputs to pins.

Reset
REQ-035 When reset=1 on a clock edge, the block SHALL go to IDLE and set CS_n=RD_n=WR_n=AD=1, bus_oe=0, bus_out=0x00, Data_R=0x00, busy=0, done=0, phase counter=0.
REQ-036 Reset SHALL take priority over start and SHALL abort any transaction in flight with no done pulse.
REQ-037 After reset is released, the first start SHALL be accepted on the next edge.

Verification
V-1 Write, T_PH=10, T_GAP=5, Address=0x02, Data=0x45 -> WR_n low for 10 cycles with AD=0, bus_out=0x02, then low for 10 cycles with AD=1, bus_out=0x45; done 66 cycles after start.
V-2 Read, Address=0x04, bus model returns 0x23 while RD_n=0 -> Data_R=0x23 at done; bus_oe=0 throughout the data cycle; WR_n stays 1 in the data cycle.
V-3 start pulsed again mid-transaction -> ignored; exactly one done pulse; latched Address/Data unchanged while Address/Data inputs change.
V-4 reset asserted in DATA_STB of a write -> next cycle WR_n=1, CS_n=1, bus_oe=0, busy=0, no done pulse; a following start completes normally.
V-5 Two back-to-back writes (0x21/0x30, then 0x22/0x59), second start on the cycle after done -> second transaction accepted, total 133 cycles, both byte sequences correct on bus_out.
V-6 Protocol checkers for the whole run -> never RD_n=WR_n=0, never bus_oe=1 with RD_n=0, CS_n=1 for exactly T_GAP cycles between the address and data cycles.
